// File: rtl/e203_tb_irq_sched_pkg.sv
// Shared types and helpers for the E203 bench interrupt scheduler: channel state
// encoding, LFSR taps and channel indices.
package e203_tb_irq_sched_pkg;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_WAIT   = 2'd1,
    CH_ASSERT = 2'd2,
    CH_STOP   = 2'd3
  } chan_state_e;

  typedef enum logic {
    TOP_IDLE  = 1'b0,
    TOP_ARMED = 1'b1
  } top_state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int CH_EXT = 0;
  localparam int CH_SFT = 1;
  localparam int CH_TMR = 2;
  localparam int CH_NUM = 3;

  // Galois right-shift LFSR step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] lfsr);
    return lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  endfunction

  // Maps the low log2 LFSR bits onto the range 1..2^log2.
  function automatic logic [31:0] rand_range(input logic [15:0] lfsr, input int log2);
    logic [31:0] mask;
    mask = (32'd1 << log2) - 32'd1;
    return ({16'h0000, lfsr} & mask) + 32'd1;
  endfunction

endpackage

// File: rtl/e203_tb_irq_sched_chan.sv
// One injection channel: LFSR-driven delay counter, state machine and irq register.
// HOLD_LOG2 > 0 turns it into a free-running window (high time also random, no ack).
module e203_tb_irq_chan
  import e203_tb_irq_sched_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] ACK_PC    = '0,
  parameter bit              ACK_EN    = 1'b1,
  parameter logic [15:0]     SEED      = 16'h0001,
  parameter int              DLY_LOG2  = 10,
  parameter int              HOLD_LOG2 = 0
) (
  input  logic            hfclk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic            i_start,
  input  logic            i_cmt_valid,
  input  logic [PC_W-1:0] i_cmt_pc,
  input  logic            i_stop,
  output logic            o_irq,
  output chan_state_e     o_state
);

  localparam int          CNT_W   = ((DLY_LOG2 > HOLD_LOG2) ? DLY_LOG2 : HOLD_LOG2) + 1;
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  chan_state_e      r_state, w_state_nxt;
  logic [15:0]      r_lfsr, w_lfsr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_dly_load, w_hold_load;
  logic             r_irq, w_irq_nxt;
  logic             w_ack, w_counting;

  assign w_ack       = ACK_EN & i_cmt_valid & (i_cmt_pc == ACK_PC);
  assign w_dly_load  = CNT_W'(rand_range(r_lfsr, DLY_LOG2));
  assign w_hold_load = CNT_W'(rand_range(r_lfsr, HOLD_LOG2));
  assign w_counting  = (r_state == CH_WAIT) || ((HOLD_LOG2 != 0) && (r_state == CH_ASSERT));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_irq_nxt   = r_irq;
    w_lfsr_nxt  = w_counting ? lfsr_step(r_lfsr) : r_lfsr;
    if (!i_en) begin
      w_state_nxt = CH_IDLE;
      w_irq_nxt   = 1'b0;
    end else begin
      case (r_state)
        CH_IDLE: begin
          if (i_start) begin
            w_state_nxt = CH_WAIT;
            w_cnt_nxt   = w_dly_load;
          end
        end
        CH_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = CH_ASSERT;
            w_irq_nxt   = 1'b1;
            if (HOLD_LOG2 != 0) w_cnt_nxt = w_hold_load;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        CH_ASSERT: begin
          if (HOLD_LOG2 != 0) begin
            if (r_cnt == CNT_W'(1)) begin
              w_state_nxt = CH_WAIT;
              w_irq_nxt   = 1'b0;
              w_cnt_nxt   = w_dly_load;
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end else if (w_ack) begin
            // Stop is only decided here so a raised irq is always acknowledged first.
            w_irq_nxt = 1'b0;
            if (i_stop) begin
              w_state_nxt = CH_STOP;
            end else begin
              w_state_nxt = CH_WAIT;
              w_cnt_nxt   = w_dly_load;
            end
          end
        end
        default: begin
          w_state_nxt = CH_STOP;
        end
      endcase
    end
  end

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CH_IDLE;
      r_lfsr  <= SEED_NZ;
      r_cnt   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  assign o_irq   = r_irq;
  assign o_state = r_state;

endmodule

// File: rtl/e203_tb_irq_sched.sv
// Bench-side interrupt scheduler: arms on PC_START, drives ext/sft/tmr irqs with random
// delays. Optional ITCM bus-error window injection under E203_TB_BUS_ERR_INJ_EN.
module e203_tb_irq_sched
  import e203_tb_irq_sched_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] PC_START   = 'h8000015C,
  parameter logic [PC_W-1:0] PC_EXT_ACK = 'h800000A6,
  parameter logic [PC_W-1:0] PC_SFT_ACK = 'h800000BE,
  parameter logic [PC_W-1:0] PC_TMR_ACK = 'h800000D6,
  parameter int              DLY_LOG2   = 10,
  parameter logic [31:0]     STOP_CNT   = 32'd32,
  parameter logic [15:0]     LFSR_SEED  = 16'hACE1
) (
  input  logic            hfclk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            cmt_valid,
  input  logic [PC_W-1:0] cmt_pc,
  input  logic [31:0]     tohost_cnt,
  input  logic            status_mie,
  input  logic            itcm_rsp_read,
  output logic            ext_irq,
  output logic            sft_irq,
  output logic            tmr_irq,
  output logic            itcm_bus_err,
  output logic            armed,
  output logic            done
  ,
  output logic            irq_quiet
);

  top_state_e  r_top, w_top_nxt;
  logic        w_arm_go, w_stop, w_done;
  logic [2:0]  w_irq;
  chan_state_e w_st [CH_NUM];

  assign w_arm_go = en & cmt_valid & (cmt_pc == PC_START) & (r_top == TOP_IDLE);
  assign w_stop   = tohost_cnt > STOP_CNT;

  always_comb begin
    w_top_nxt = r_top;
    if (!en)           w_top_nxt = TOP_IDLE;
    else if (w_arm_go) w_top_nxt = TOP_ARMED;
  end

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) r_top <= TOP_IDLE;
    else        r_top <= w_top_nxt;
  end

  e203_tb_irq_chan #(
    .PC_W(PC_W), .ACK_PC(PC_EXT_ACK), .ACK_EN(1'b1),
    .SEED(LFSR_SEED + 16'd0), .DLY_LOG2(DLY_LOG2), .HOLD_LOG2(0)
  ) u_chan_ext (
    .hfclk(hfclk), .rst_n(rst_n), .i_en(en), .i_start(w_arm_go),
    .i_cmt_valid(cmt_valid), .i_cmt_pc(cmt_pc), .i_stop(w_stop),
    .o_irq(w_irq[CH_EXT]), .o_state(w_st[CH_EXT])
  );

  e203_tb_irq_chan #(
    .PC_W(PC_W), .ACK_PC(PC_SFT_ACK), .ACK_EN(1'b1),
    .SEED(LFSR_SEED + 16'd1), .DLY_LOG2(DLY_LOG2), .HOLD_LOG2(0)
  ) u_chan_sft (
    .hfclk(hfclk), .rst_n(rst_n), .i_en(en), .i_start(w_arm_go),
    .i_cmt_valid(cmt_valid), .i_cmt_pc(cmt_pc), .i_stop(w_stop),
    .o_irq(w_irq[CH_SFT]), .o_state(w_st[CH_SFT])
  );

  e203_tb_irq_chan #(
    .PC_W(PC_W), .ACK_PC(PC_TMR_ACK), .ACK_EN(1'b1),
    .SEED(LFSR_SEED + 16'd2), .DLY_LOG2(DLY_LOG2), .HOLD_LOG2(0)
  ) u_chan_tmr (
    .hfclk(hfclk), .rst_n(rst_n), .i_en(en), .i_start(w_arm_go),
    .i_cmt_valid(cmt_valid), .i_cmt_pc(cmt_pc), .i_stop(w_stop),
    .o_irq(w_irq[CH_TMR]), .o_state(w_st[CH_TMR])
  );

  assign w_done = (w_st[CH_EXT] == CH_STOP) & (w_st[CH_SFT] == CH_STOP) &
                  (w_st[CH_TMR] == CH_STOP);

`ifdef E203_TB_BUS_ERR_INJ_EN
  logic        w_err_en, w_err_win;
  chan_state_e w_unused_err_st;

  // Window runs only while injection is live; low 1..32 cycles, high 1..256 cycles.
  assign w_err_en = en & (r_top == TOP_ARMED) & ~w_done;

  e203_tb_irq_chan #(
    .PC_W(PC_W), .ACK_PC('0), .ACK_EN(1'b0),
    .SEED(LFSR_SEED + 16'd3), .DLY_LOG2(5), .HOLD_LOG2(8)
  ) u_chan_err (
    .hfclk(hfclk), .rst_n(rst_n), .i_en(w_err_en), .i_start(w_err_en),
    .i_cmt_valid(1'b0), .i_cmt_pc('0), .i_stop(1'b0),
    .o_irq(w_err_win), .o_state(w_unused_err_st)
  );

  assign itcm_bus_err = w_err_win & status_mie & itcm_rsp_read;
`else
  logic w_unused_err_in;
  assign w_unused_err_in = status_mie ^ itcm_rsp_read;
  assign itcm_bus_err    = 1'b0;
`endif

  assign ext_irq   = w_irq[CH_EXT];
  assign sft_irq   = w_irq[CH_SFT];
  assign tmr_irq   = w_irq[CH_TMR];
  assign armed     = (r_top == TOP_ARMED);
  assign done      = w_done;
  assign irq_quiet = ~(|w_irq);

endmodule

// File: tb/tb_e203_tb_irq_sched.sv
// Randomized self-checking bench for e203_tb_irq_sched with a cycle-level behavioural
// model of arming, random delays, acks, stop threshold, enable drop and async reset.
module tb_e203_tb_irq_sched;

  localparam logic [31:0] PC_START = 32'h8000015C;
  localparam logic [31:0] ACK_PC [3] = '{32'h800000A6, 32'h800000BE, 32'h800000D6};
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_ASSERT = 2, PH_STOP = 3;

  logic        hfclk, rst_n, en, cmt_valid, status_mie, itcm_rsp_read;
  logic [31:0] cmt_pc, tohost_cnt;
  logic        ext_irq, sft_irq, tmr_irq, itcm_bus_err, armed, done, irq_quiet;

  int          n_chk, n_err, cyc;
  bit          m_armed;
  int          m_ph [3];
  int          m_left [3];
  int          m_entry [3];
  logic [15:0] m_lfsr [3];
  logic [2:0]  prev_irq;

  e203_tb_irq_sched #(.DLY_LOG2(2), .LFSR_SEED(16'h0003)) dut (
    .hfclk(hfclk), .rst_n(rst_n), .en(en), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .tohost_cnt(tohost_cnt), .status_mie(status_mie), .itcm_rsp_read(itcm_rsp_read),
    .ext_irq(ext_irq), .sft_irq(sft_irq), .tmr_irq(tmr_irq), .itcm_bus_err(itcm_bus_err),
    .armed(armed), .done(done), .irq_quiet(irq_quiet)
  );

  initial hfclk = 1'b0;
  always #5 hfclk = ~hfclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic bit all_stop();
    return m_ph[0] == PH_STOP && m_ph[1] == PH_STOP && m_ph[2] == PH_STOP;
  endfunction

  function automatic logic [2:0] m_irq();
    return {m_ph[0] == PH_ASSERT, m_ph[1] == PH_ASSERT, m_ph[2] == PH_ASSERT};
  endfunction

  task automatic model_reset();
    m_armed  = 1'b0;
    prev_irq = 3'b000;
    for (int k = 0; k < 3; k++) begin
      m_ph[k]   = PH_IDLE;
      m_left[k] = 0;
      m_lfsr[k] = 16'h0003 + 16'(k);
    end
  endtask

  // Delay = low two LFSR bits + 1; LFSR moves once per cycle spent waiting.
  task automatic model_step();
    bit go;
    go = en && !m_armed && cmt_valid && cmt_pc == PC_START;
    if (!en) m_armed = 1'b0;
    else if (go) m_armed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit          was_wait;
      logic [15:0] l_now;
      was_wait = (m_ph[k] == PH_WAIT);
      l_now    = m_lfsr[k];
      if (!en) m_ph[k] = PH_IDLE;
      else begin
        case (m_ph[k])
          PH_IDLE: if (go) begin
            m_ph[k] = PH_WAIT; m_left[k] = int'(l_now % 4) + 1; m_entry[k] = cyc;
          end
          PH_WAIT: begin
            m_left[k]--;
            if (m_left[k] == 0) m_ph[k] = PH_ASSERT;
          end
          PH_ASSERT: if (cmt_valid && cmt_pc == ACK_PC[k]) begin
            if (tohost_cnt > 32'd32) m_ph[k] = PH_STOP;
            else begin
              m_ph[k] = PH_WAIT; m_left[k] = int'(l_now % 4) + 1; m_entry[k] = cyc;
            end
          end
          default: ;
        endcase
      end
      if (was_wait) m_lfsr[k] = lfsr_next(l_now);
    end
  endtask

  task automatic step(input logic en_v, input logic cv, input logic [31:0] pc, input logic [31:0] th);
    logic [2:0] obs_irq;
    @(negedge hfclk);
    en = en_v; cmt_valid = cv; cmt_pc = pc; tohost_cnt = th;
    status_mie = 1'($urandom); itcm_rsp_read = 1'($urandom);
    @(posedge hfclk);
    cyc++;
    model_step();
    #1;
    obs_irq = {ext_irq, sft_irq, tmr_irq};
    chk("outs", 32'({armed, done, irq_quiet, obs_irq}),
        32'({m_armed, all_stop(), ~|m_irq(), m_irq()}));
`ifdef E203_TB_BUS_ERR_INJ_EN
    chk("bus_err_gate", 32'(itcm_bus_err & ~(status_mie & itcm_rsp_read & m_armed & ~all_stop())), 32'd0);
`else
    chk("bus_err_tied", 32'(itcm_bus_err), 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      if (obs_irq[2-k] && !prev_irq[2-k])
        chk("rise_dly_in_1_4", 32'((cyc - m_entry[k]) >= 1 && (cyc - m_entry[k]) <= 4), 32'd1);
    end
    prev_irq = obs_irq;
  endtask

  function automatic logic [31:0] rand_pc(input bit allow_start);
    case ($urandom_range(0, 5))
      0: return ACK_PC[0];
      1: return ACK_PC[1];
      2: return ACK_PC[2];
      3: return allow_start ? PC_START : 32'h80010000;
      default: return 32'h80010000 | ($urandom & 32'h0000FFFC);
    endcase
  endfunction

  task automatic rnd_step(input logic [31:0] th, input bit allow_start);
    step(1'b1, 1'($urandom), rand_pc(allow_start), th);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; en = 1'b0; cmt_valid = 1'b0; cmt_pc = '0; tohost_cnt = '0;
    status_mie = 1'b0; itcm_rsp_read = 1'b0;
    model_reset();
    repeat (3) @(posedge hfclk);
    #1;
    chk("reset_outs", 32'({armed, done, irq_quiet, ext_irq, sft_irq, tmr_irq, itcm_bus_err}),
        32'b0010000);
    @(negedge hfclk); rst_n = 1'b1;

    // Enabled but never armed.
    repeat (5000) rnd_step($urandom_range(0, 32), 1'b0);
    chk("no_start_armed", 32'(armed), 32'd0);

    // Arm, then an ack to a channel that is not asserted.
    step(1'b1, 1'b1, PC_START, 32'd0);
    chk("armed_after_start", 32'(armed), 32'd1);
    step(1'b1, 1'b1, ACK_PC[1], 32'd0);
    repeat (3000) rnd_step($urandom_range(0, 32), 1'b1);

    // Drop enable while the timer irq is high.
    for (int i = 0; i < 500 && m_ph[2] != PH_ASSERT; i++) rnd_step(32'd32, 1'b1);
    chk("tmr_asserted_before_drop", 32'(m_ph[2] == PH_ASSERT), 32'd1);
    step(1'b0, 1'b0, 32'h0, 32'd0);
    chk("tmr_drop", 32'(tmr_irq), 32'd0);
    chk("armed_drop", 32'(armed), 32'd0);
    step(1'b1, 1'b1, PC_START, 32'd0);
    repeat (1000) rnd_step($urandom_range(0, 32), 1'b1);

    // Stop threshold crossed: ack asserted channels until all have stopped.
    for (int i = 0; i < 3000 && !all_stop(); i++) begin
      logic [31:0] pc;
      pc = rand_pc(1'b0);
      for (int k = 0; k < 3; k++) if (m_ph[k] == PH_ASSERT && $urandom_range(0, 1) == 1) pc = ACK_PC[k];
      step(1'b1, 1'b1, pc, 32'd33);
    end
    chk("done_after_acks", 32'(done), 32'd1);
    repeat (10000) rnd_step(32'd33 + $urandom_range(0, 1000), 1'b1);
    chk("quiet_after_stop", 32'({irq_quiet, done}), 32'b11);

    // Async reset while an irq is asserted.
    step(1'b0, 1'b0, 32'h0, 32'd0);
    step(1'b1, 1'b1, PC_START, 32'd0);
    for (int i = 0; i < 20 && m_irq() == 3'b000; i++) rnd_step(32'd0, 1'b0);
    chk("irq_before_reset", 32'(m_irq() != 3'b000), 32'd1);
    @(posedge hfclk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_drop_irq", 32'({ext_irq, sft_irq, tmr_irq, armed}), 32'd0);
    model_reset();
    @(negedge hfclk); rst_n = 1'b1;
    repeat (50) rnd_step(32'd0, 1'b0);
    step(1'b1, 1'b1, PC_START, 32'd0);
    repeat (200) rnd_step($urandom_range(0, 32), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
